ship_motion_ctrl: RTL and testbench
===================================

Name: ship_motion_ctrl

Overview:
Sequences the spaceship sprite position once per video frame. It takes accelerometer tilt samples or debounced push-button steps and computes a clamped new X coordinate. It commits ship_x/ship_y only inside a short post-frame window, so the sprite never tears mid-frame. It sits between the input sources (accelerometer reader, KEY/SW) and the spaceship sprite's sprite_x/sprite_y inputs, in the clk_pix domain.

Parameters:
H_RES, 640, horizontal screen resolution in pixels
SCREEN_CORDW, 16, width of screen coordinates
SHIP_W_PIX, 68, on-screen ship width (17 x scale 4); right clamp = H_RES-SHIP_W_PIX
START_X, 286, ship_x after reset
START_Y, 300, ship_y after reset (constant during operation)
TILT_W, 12, width of signed two's-complement tilt sample
DEADZONE, 32, tilt magnitude at or below which velocity is 0
TILT_SHIFT, 5, right shift applied to (|tilt|-DEADZONE) to form speed
MAX_SPEED, 8, speed saturation in pixels/frame
BTN_STEP, 4, pixels moved per consumed button step
DB_CYCLES, 250000, debounce stable-time in clk_pix cycles (10 ms at 25 MHz)

Ports:
clk_pix  in  1  pixel clock, all logic posedge
rst  in  1  asynchronous, active-high reset
frame  in  1  one-cycle pulse at start of each frame
mode  in  1  0 = tilt control, 1 = button control
tilt_x  in  TILT_W  signed tilt sample; positive moves the ship right
tilt_valid  in  1  one-cycle strobe qualifying tilt_x
btn_n  in  1  raw step button, active-low, asynchronous to clk_pix
btn_dir  in  1  1 = step right, 0 = step left (level, sampled at press)
ship_x  out  SCREEN_CORDW  committed sprite X
ship_y  out  SCREEN_CORDW  committed sprite Y
update  out  1  one-cycle pulse when ship_x is committed
at_left  out  1  ship_x == 0
at_right  out  1  ship_x == H_RES-SHIP_W_PIX
overrun  out  1  sticky: frame arrived while FSM not IDLE

Behaviour:
- Reset values: ship_x=START_X, ship_y=START_Y, update=0, overrun=0, at_left=0, at_right=0. Pending steps, tilt latch, debouncer, and FSM all clear to 0/IDLE. Reset mid-sequence aborts the sequence with no commit.
- Input sync: btn_n passes through a 2-flop synchronizer, then the debouncer. The debounced level changes only after the synchronized input has been stable for DB_CYCLES consecutive cycles.
- Step capture: a debounced 1->0 transition with btn_dir=1 does pend_cnt+1; with btn_dir=0 it does pend_cnt-1.
- pend_cnt is a signed 5-bit count saturating at +15/-15.
- A capture and a consumption in the same cycle are both applied; the net result is saturated.
- Tilt latch: tilt_x is captured on tilt_valid. The latch holds its last value, never decays, and updates in any FSM state.
- FSM states: IDLE -> SAMPLE -> CALC -> CLAMP -> COMMIT -> IDLE. Each non-IDLE state lasts exactly 1 cycle.
  - IDLE: on frame go to SAMPLE.
  - SAMPLE: snapshot the tilt latch, mode, and sign of pend_cnt.
  - CALC: compute a signed velocity v (see velocity rules below).
  - CLAMP: nx = ship_x + v evaluated in SCREEN_CORDW+1 signed bits. If nx<0, nx=0; if nx>H_RES-SHIP_W_PIX, nx=H_RES-SHIP_W_PIX.
  - COMMIT: ship_x<=nx and update=1 for this one cycle only.
- Velocity in tilt mode:
  - a=|tilt| computed in TILT_W+1 bits, so -2^(TILT_W-1) is legal.
  - a<=DEADZONE gives v=0.
  - Otherwise s=min((a-DEADZONE)>>TILT_SHIFT, MAX_SPEED) and v=sign(tilt)*s.
- Velocity in button mode: v=+BTN_STEP if pend_cnt>0, -BTN_STEP if pend_cnt<0, else 0. A nonzero pend_cnt moves one unit toward 0 in CALC (consumption).
- Latency: update is high exactly 5 cycles after the frame pulse cycle (frame at cycle n gives update at n+5). ship_x is stable for all other cycles.
- frame while not IDLE: ignored, and overrun is set. overrun clears only on rst.
- at_left/at_right are registered and updated with ship_x. update pulses even when nx equals the old ship_x.
- ship_y holds START_Y always (reserved for future vertical control).
- Mode change takes effect at the next SAMPLE. pend_cnt is retained across mode changes.

Test Plan:
1. Reset release, no frames -> ship_x=286, ship_y=300, update=0, overrun=0.
2. mode=0, tilt_x=+320 strobed, frame at n -> update at n+5, ship_x=286+min((320-32)>>5,8)=294. tilt_x=+20 then frame -> ship_x stays 294 with update pulsed.
3. mode=0, tilt_x=-2048, 40 frames -> v=-8 per frame; ship_x reaches 0 at frame 36, at_left=1, no underflow. tilt=+2047 then drives ship_x to 572 and holds it, at_right=1.
4. mode=1, btn_dir=1, three clean presses with DB_CYCLES shortened to 8, then 4 frames -> ship_x 286->290->294->298 and stays 298 on the 4th frame. A 5-cycle glitch on btn_n adds no step.
5. frame pulses at n and n+2 -> single update at n+5, overrun=1 sticky. Assert rst at n+3 -> no update, ship_x=286, overrun=0.
6. mode=1, 20 right presses -> pend_cnt saturates at 15; a press coincident with a CALC consumption yields pend_cnt unchanged.

Source files
------------

// File: rtl/ship_motion_ctrl.sv
// Per-frame spaceship X sequencer: tilt or button steps in, clamped ship_x out.
// Position commits only in a short post-frame window so the sprite never tears.
module ship_motion_ctrl #(
    parameter int H_RES        = 640,
    parameter int SCREEN_CORDW = 16,
    parameter int SHIP_W_PIX   = 68,
    parameter int START_X      = 286,
    parameter int START_Y      = 300,
    parameter int TILT_W       = 12,
    parameter int DEADZONE     = 32,
    parameter int TILT_SHIFT   = 5,
    parameter int MAX_SPEED    = 8,
    parameter int BTN_STEP     = 4,
    parameter int DB_CYCLES    = 250000
) (
    input  logic                    clk_pix,
    input  logic                    rst,
    input  logic                    frame,
    input  logic                    mode,
    input  logic [TILT_W-1:0]       tilt_x,
    input  logic                    tilt_valid,
    input  logic                    btn_n,
    input  logic                    btn_dir,
    output logic [SCREEN_CORDW-1:0] ship_x,
    output logic [SCREEN_CORDW-1:0] ship_y,
    output logic                    update,
    output logic                    at_left,
    output logic                    at_right,
    output logic                    overrun
);

    localparam int CW  = SCREEN_CORDW;
    localparam int DBW = $clog2(DB_CYCLES + 1);

    localparam logic signed [CW:0] X_MAX  = (CW+1)'(H_RES - SHIP_W_PIX);
    localparam logic signed [CW:0] STEP_V = (CW+1)'(BTN_STEP);
    localparam logic [TILT_W:0] DZ       = (TILT_W+1)'(DEADZONE);
    localparam logic [TILT_W:0] SPD_MAX  = (TILT_W+1)'(MAX_SPEED);
    localparam logic [DBW-1:0]  DB_LAST  = DBW'(DB_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, SAMPLE, CALC, CLAMP, COMMIT
    } state_t;

    state_t state;

    logic              sync1, sync2;
    logic              db_lvl, db_prev;
    logic [DBW-1:0]    db_cnt;
    logic              press;

    logic signed [TILT_W-1:0] tilt_q;
    logic signed [TILT_W-1:0] tilt_s;
    logic                     mode_s;
    logic                     pos_s, neg_s;

    logic signed [4:0] pend_cnt;
    logic signed [4:0] pend_nxt;
    logic signed [6:0] pend_sum;
    logic signed [6:0] cap_d, cons_d;
    logic              consume;

    logic signed [TILT_W:0] tilt_ext;
    logic [TILT_W:0]        tilt_abs;
    logic [TILT_W:0]        spd_raw;
    logic [TILT_W:0]        spd;
    logic signed [CW:0]     vel_c, vel_q;
    logic signed [CW:0]     sum;
    logic [CW-1:0]          nx_c, nx_q;

    assign ship_y = CW'(START_Y);

    // Synchronizer plus debouncer: level follows sync2 only after a full stable run
    always_ff @(posedge clk_pix or posedge rst) begin
        if (rst) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            db_lvl  <= 1'b0;
            db_prev <= 1'b0;
            db_cnt  <= '0;
        end else begin
            sync1   <= btn_n;
            sync2   <= sync1;
            db_prev <= db_lvl;
            if (sync2 != db_lvl) begin
                if (db_cnt == DB_LAST) begin
                    db_lvl <= sync2;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    assign press = db_prev & ~db_lvl;

    always_ff @(posedge clk_pix or posedge rst) begin
        if (rst) begin
            tilt_q <= '0;
        end else if (tilt_valid) begin
            tilt_q <= tilt_x;
        end
    end

    // Capture and consumption may coincide; apply both, then saturate
    always_comb begin
        consume = (state == CALC) && mode_s && (pend_cnt != 5'sd0);
        cap_d   = 7'sd0;
        cons_d  = 7'sd0;
        if (press) begin
            cap_d = btn_dir ? 7'sd1 : -7'sd1;
        end
        if (consume) begin
            cons_d = (pend_cnt > 5'sd0) ? 7'sd1 : -7'sd1;
        end
        pend_sum = 7'(pend_cnt) + cap_d - cons_d;
        if (pend_sum > 7'sd15) begin
            pend_nxt = 5'sd15;
        end else if (pend_sum < -7'sd15) begin
            pend_nxt = -5'sd15;
        end else begin
            pend_nxt = pend_sum[4:0];
        end
    end

    // |tilt| needs one extra bit so the most negative sample is legal
    always_comb begin
        tilt_ext = (TILT_W+1)'(tilt_s);
        tilt_abs = (tilt_ext < 0) ? unsigned'(-tilt_ext) : unsigned'(tilt_ext);
        spd_raw  = '0;
        if (tilt_abs > DZ) begin
            spd_raw = (tilt_abs - DZ) >> TILT_SHIFT;
        end
        spd = (spd_raw > SPD_MAX) ? SPD_MAX : spd_raw;
        vel_c = '0;
        unique case (1'b1)
            (!mode_s && (tilt_ext < 0)): vel_c = -signed'((CW+1)'(spd));
            (!mode_s && (tilt_ext >= 0)): vel_c = signed'((CW+1)'(spd));
            (mode_s && pos_s): vel_c = STEP_V;
            (mode_s && neg_s): vel_c = -STEP_V;
            default: vel_c = '0;
        endcase
    end

    always_comb begin
        sum = signed'({1'b0, ship_x}) + vel_q;
        if (sum < 0) begin
            nx_c = '0;
        end else if (sum > X_MAX) begin
            nx_c = X_MAX[CW-1:0];
        end else begin
            nx_c = sum[CW-1:0];
        end
    end

    always_ff @(posedge clk_pix or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ship_x   <= CW'(START_X);
            update   <= 1'b0;
            overrun  <= 1'b0;
            at_left  <= 1'b0;
            at_right <= 1'b0;
            pend_cnt <= '0;
            tilt_s   <= '0;
            mode_s   <= 1'b0;
            pos_s    <= 1'b0;
            neg_s    <= 1'b0;
            vel_q    <= '0;
            nx_q     <= '0;
        end else begin
            update   <= 1'b0;
            pend_cnt <= pend_nxt;
            if (frame && (state != IDLE)) begin
                overrun <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (frame) begin
                        state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    tilt_s <= tilt_q;
                    mode_s <= mode;
                    pos_s  <= (pend_cnt > 5'sd0);
                    neg_s  <= (pend_cnt < 5'sd0);
                    state  <= CALC;
                end
                CALC: begin
                    vel_q <= vel_c;
                    state <= CLAMP;
                end
                CLAMP: begin
                    nx_q  <= nx_c;
                    state <= COMMIT;
                end
                COMMIT: begin
                    ship_x   <= nx_q;
                    update   <= 1'b1;
                    at_left  <= (nx_q == '0);
                    at_right <= (nx_q == X_MAX[CW-1:0]);
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ship_motion_ctrl.sv
// Directed bench for ship_motion_ctrl with a queue of expected commits.
// Debounce time is shortened to 8 cycles to keep button tests short.
module tb_ship_motion_ctrl;

    localparam int XMAX = 572;

    logic               clk_pix = 1'b0;
    logic               rst;
    logic               frame;
    logic               mode;
    logic signed [11:0] tilt_x;
    logic               tilt_valid;
    logic               btn_n;
    logic               btn_dir;
    logic [15:0]        ship_x;
    logic [15:0]        ship_y;
    logic               update;
    logic               at_left;
    logic               at_right;
    logic               overrun;

    ship_motion_ctrl #(.DB_CYCLES(8)) dut (
        .clk_pix    (clk_pix),
        .rst        (rst),
        .frame      (frame),
        .mode       (mode),
        .tilt_x     (tilt_x),
        .tilt_valid (tilt_valid),
        .btn_n      (btn_n),
        .btn_dir    (btn_dir),
        .ship_x     (ship_x),
        .ship_y     (ship_y),
        .update     (update),
        .at_left    (at_left),
        .at_right   (at_right),
        .overrun    (overrun)
    );

    always #5 clk_pix = ~clk_pix;

    typedef struct {
        int x;
        bit al;
        bit ar;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   model_x;
    int   pend_m;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_pix);
        #1;
    endtask

    function automatic int tilt_v(input int t);
        int a;
        a = (t < 0) ? -t : t;
        if (a <= 32) return 0;
        a = (a - 32) / 32;
        if (a > 8) a = 8;
        return (t < 0) ? -a : a;
    endfunction

    function automatic int btn_v(input int p);
        if (p > 0) return 4;
        if (p < 0) return -4;
        return 0;
    endfunction

    task automatic push_exp(input int v);
        exp_t e;
        model_x = model_x + v;
        if (model_x < 0) model_x = 0;
        if (model_x > XMAX) model_x = XMAX;
        e.x  = model_x;
        e.al = (model_x == 0);
        e.ar = (model_x == XMAX);
        sb.push_back(e);
    endtask

    task automatic run_frame(input string tag, input int v);
        int   lat;
        bit   got;
        exp_t e;
        push_exp(v);
        frame = 1'b1;
        lat = 0;
        got = 1'b0;
        while (lat < 12 && !got) begin
            tick();
            lat++;
            if (lat == 1) frame = 1'b0;
            if (update) got = 1'b1;
        end
        e = sb.pop_front();
        chk({tag, "_seen"}, 32'(got), 32'd1);
        if (got) begin
            chk({tag, "_lat"}, lat, 5);
            chk({tag, "_x"}, ship_x, e.x);
            chk({tag, "_al"}, at_left, e.al);
            chk({tag, "_ar"}, at_right, e.ar);
            tick();
            chk({tag, "_pulse"}, update, 0);
        end
    endtask

    task automatic strobe_tilt(input int t);
        tilt_x = 12'(t);
        tilt_valid = 1'b1;
        tick();
        tilt_valid = 1'b0;
    endtask

    task automatic press(input bit dir);
        btn_dir = dir;
        btn_n = 1'b0;
        repeat (14) tick();
        btn_n = 1'b1;
        repeat (14) tick();
        pend_m = dir ? pend_m + 1 : pend_m - 1;
        if (pend_m > 15) pend_m = 15;
        if (pend_m < -15) pend_m = -15;
    endtask

    task automatic btn_frame(input string tag);
        int v;
        v = btn_v(pend_m);
        if (pend_m > 0) pend_m--;
        else if (pend_m < 0) pend_m++;
        run_frame(tag, v);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        frame = 1'b0;
        tilt_valid = 1'b0;
        btn_n = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        repeat (20) tick();
        model_x = 286;
        pend_m = 0;
        sb.delete();
    endtask

    initial begin
        int ups;
        mode = 1'b0;
        tilt_x = '0;
        btn_dir = 1'b1;
        do_reset();

        chk("rst_x", ship_x, 286);
        chk("rst_y", ship_y, 300);
        chk("rst_upd", update, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_al", at_left, 0);
        chk("rst_ar", at_right, 0);

        strobe_tilt(320);
        run_frame("tilt320", tilt_v(320));
        chk("tilt320_abs", ship_x, 294);
        strobe_tilt(20);
        run_frame("tilt20", tilt_v(20));
        chk("tilt20_abs", ship_x, 294);

        do_reset();
        strobe_tilt(-2048);
        for (int i = 0; i < 40; i++) begin
            run_frame("left", tilt_v(-2048));
            if (i == 35) chk("left_f36", ship_x, 0);
        end
        chk("left_hold_al", at_left, 1);
        strobe_tilt(2047);
        for (int i = 0; i < 75; i++) run_frame("right", tilt_v(2047));
        chk("right_hold", ship_x, XMAX);
        chk("right_ar", at_right, 1);

        do_reset();
        mode = 1'b1;
        repeat (3) press(1'b1);
        for (int i = 0; i < 4; i++) btn_frame("btn");
        chk("btn_end", ship_x, 298);
        btn_n = 1'b0;
        repeat (5) tick();
        btn_n = 1'b1;
        repeat (20) tick();
        btn_frame("glitch");
        chk("glitch_x", ship_x, 298);

        do_reset();
        mode = 1'b0;
        strobe_tilt(320);
        push_exp(tilt_v(320));
        frame = 1'b1;
        ups = 0;
        for (int lat = 1; lat <= 10; lat++) begin
            tick();
            frame = (lat == 2);
            if (update) begin
                ups++;
                chk("ovr_lat", lat, 5);
            end
        end
        chk("ovr_ups", ups, 1);
        begin
            exp_t e;
            e = sb.pop_front();
            chk("ovr_x", ship_x, e.x);
        end
        chk("ovr_sticky", overrun, 1);

        frame = 1'b1;
        ups = 0;
        for (int lat = 1; lat <= 12; lat++) begin
            tick();
            frame = (lat == 2);
            if (lat == 3) rst = 1'b1;
            if (lat == 5) rst = 1'b0;
            if (update) ups++;
        end
        chk("abort_ups", ups, 0);
        chk("abort_x", ship_x, 286);
        chk("abort_ovr", overrun, 0);

        do_reset();
        mode = 1'b1;
        repeat (20) press(1'b1);
        chk("sat_model", pend_m, 15);
        btn_dir = 1'b1;
        btn_n = 1'b0;
        repeat (8) tick();
        run_frame("coinc", btn_v(pend_m));
        btn_n = 1'b1;
        repeat (14) tick();
        for (int i = 0; i < 16; i++) btn_frame("drain");
        chk("drain_end", ship_x, 350);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
